shared_divider: RTL and testbench

Shared sequential unsigned divider serving the bike computer's statistic blocks (average speed and similar) over the common divider bus. A client places dividend and divisor on `dividerbus`, pulses `start`, watches Busy, and collects the quotient on `dividerres` when Ready rises. One restoring-division iteration runs per clock, so a single small datapath is time-shared instead of instantiating a combinational divider in every client.

---
 rtl/shared_divider.sv | 94 +++++++++
 tb/tb_shared_divider.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/shared_divider.sv
// Time-shared restoring unsigned divider: one quotient bit per clock, result held on dividerres with a Ready level.
// Optional round-to-nearest quotient when DIVIDER_ROUND_EN is defined; default build truncates (floor).
module shared_divider #(
    parameter int WIDTH_div = 16
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic [2*WIDTH_div-1:0] dividerbus,
    input  logic                   start,
    output logic [WIDTH_div-1:0]   dividerres,
    output logic [1:0]             dividercontrol
);

    localparam int CNT_W = $clog2(WIDTH_div + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t               state;
    logic [WIDTH_div-1:0] dvd;   // dividend, shifts out as quotient bits shift in
    logic [WIDTH_div-1:0] dvs;
    logic [WIDTH_div-1:0] rem;
    logic [CNT_W-1:0]     cnt;
    logic                 busy;
    logic                 ready;

    logic [WIDTH_div:0]   partial;
    logic                 ge;
    logic [WIDTH_div-1:0] trial;
    logic [WIDTH_div-1:0] rem_next;
    logic [WIDTH_div-1:0] quo_next;
    logic [WIDTH_div-1:0] final_q;

    // NOTE: every always_comb output gets a value before any condition so no latch is inferred.
    always_comb begin
        partial  = {rem, dvd[WIDTH_div-1]};
        ge       = partial >= {1'b0, dvs};
        // A passing trial leaves the top partial bit zero, so the low bits suffice.
        trial    = partial[WIDTH_div-1:0] - dvs;
        rem_next = ge ? trial : partial[WIDTH_div-1:0];
        quo_next = {dvd[WIDTH_div-2:0], ge};
        final_q  = quo_next;
`ifdef DIVIDER_ROUND_EN
        // Round half up, saturating so an all-ones quotient never wraps to zero.
        if (({rem_next, 1'b0} >= {1'b0, dvs}) && (quo_next != '1))
            final_q = quo_next + 1'b1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!r) begin
            state      <= IDLE;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            dividerres <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= dividerbus[2*WIDTH_div-1:WIDTH_div];
                        dvs   <= dividerbus[WIDTH_div-1:0];
                        rem   <= '0;
                        cnt   <= CNT_W'(WIDTH_div);
                        busy  <= 1'b1;
                        ready <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= quo_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        dividerres <= final_q;
                        busy       <= 1'b0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dividercontrol = {busy, ready};

endmodule

// File: tb/tb_shared_divider.sv
// Directed self-checking bench for shared_divider (default truncating build, WIDTH_div=16).
module tb_shared_divider;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           r = 1'b0;
    logic [2*W-1:0] dividerbus = '0;
    logic           start = 1'b0;
    logic [W-1:0]   dividerres;
    logic [1:0]     dividercontrol;

    int n_vec = 0;
    int n_err = 0;

    shared_divider #(.WIDTH_div(W)) dut (
        .clk           (clk),
        .r             (r),
        .dividerbus    (dividerbus),
        .start         (start),
        .dividerres    (dividerres),
        .dividercontrol(dividercontrol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on the negedge right after an accept; returns negedges until Ready shows.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (dividercontrol !== 2'b01 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp);
        int cyc;
        @(negedge clk);
        dividerbus = {a, b};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(dividercontrol), 32'(2'b10));
        wait_ready(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(W));
        check({tag, "_q"}, 32'(dividerres), 32'(exp));
    endtask

    initial begin
        int cyc;

        repeat (3) @(negedge clk);
        check("rst_res", 32'(dividerres), 32'h0);
        check("rst_ctl", 32'(dividercontrol), 32'h0);
        r = 1'b1;

        // Basic division and Ready held as a level
        run_div("basic", 16'd36000, 16'd120, 16'd300);
        repeat (3) @(negedge clk);
        check("hold_ctl", 32'(dividercontrol), 32'(2'b01));
        check("hold_res", 32'(dividerres), 32'd300);

        run_div("trunc7_2", 16'd7, 16'd2, 16'd3);
        run_div("max_2", 16'hFFFF, 16'd2, 16'd32767);
        run_div("max_1", 16'hFFFF, 16'd1, 16'hFFFF);
        run_div("max_max", 16'hFFFF, 16'hFFFF, 16'd1);
        run_div("small", 16'd5, 16'd9, 16'd0);
        run_div("zero_dvd", 16'd0, 16'd5, 16'd0);
        run_div("div0", 16'd1234, 16'd0, 16'hFFFF);
        check("div0_ready", 32'(dividercontrol), 32'(2'b01));

        // Start during CALC is ignored, bus changes after accept do not matter
        @(negedge clk);
        dividerbus = {16'd100, 16'd7};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividerbus = {16'd50, 16'd5};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 6;
        while (dividercontrol !== 2'b01 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ign_lat", 32'(cyc), 32'(W));
        check("ign_q", 32'(dividerres), 32'd14);

        // Reset mid-operation
        @(negedge clk);
        dividerbus = {16'd200, 16'd3};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        check("midrst_ctl", 32'(dividercontrol), 32'h0);
        check("midrst_res", 32'(dividerres), 32'h0);
        r = 1'b1;
        run_div("after_rst", 16'd9, 16'd3, 16'd3);

        // Back-to-back with start held high
        @(negedge clk);
        dividerbus = {16'd1000, 16'd10};
        start = 1'b1;
        @(negedge clk);
        check("b2b_busy1", 32'(dividercontrol), 32'(2'b10));
        wait_ready(cyc);
        check("b2b_lat1", 32'(cyc), 32'(W));
        check("b2b_q1", 32'(dividerres), 32'd100);
        dividerbus = {16'd1000, 16'd3};
        @(negedge clk);
        check("b2b_reacc", 32'(dividercontrol), 32'(2'b10));
        check("b2b_hold", 32'(dividerres), 32'd100);
        wait_ready(cyc);
        start = 1'b0;
        check("b2b_period", 32'(cyc + 1), 32'(W + 1));
        check("b2b_q2", 32'(dividerres), 32'd333);

        // Start coincident with the final CALC edge is not queued
        @(negedge clk);
        dividerbus = {16'd20, 16'd4};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W - 1) @(negedge clk);
        dividerbus = {16'd30, 16'd3};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("final_q", 32'(dividerres), 32'd5);
        @(negedge clk);
        check("final_noacc", 32'(dividercontrol), 32'(2'b01));
        repeat (2) @(negedge clk);
        check("final_hold", 32'(dividerres), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
